// File: rtl/sign_narrow_tx.sv
// sign_narrow_tx: splits 32-bit words into a 16-bit halfword stream.
// A word that survives 16->32 sign extension unchanged goes out as one
// beat tagged out_ext=1. Any other word goes out as two beats, high half
// first. Bit 0 is the MSB on every bus.
// Optional feature macro: SIGN_NARROW_STATS_EN adds saturating
// cnt_short / cnt_long word counters.
module sign_narrow_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:15] out_data,
  output logic        out_ext,
  output logic        out_last
`ifdef SIGN_NARROW_STATS_EN
  ,
  output logic [0:15] cnt_short,
  output logic [0:15] cnt_long
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SHORT,
    ST_HI,
    ST_LO
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [0:31] hold;
  logic        accept;
  logic        in_short;

  // A word is short when its top 17 bits are all copies of the sign bit.
  assign in_short = (in_data[0:16] == 17'h00000) || (in_data[0:16] == 17'h1ffff);
  assign accept   = in_valid && in_ready;

  // Space opens up when idle, or when the final beat leaves this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state == ST_EMPTY)
        in_ready = 1'b1;
      else if ((state == ST_SHORT || state == ST_LO) && out_ready)
        in_ready = 1'b1;
    end
  end

  // Next-state selection; a new word can replace the final beat with no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (accept)
          state_nxt = in_short ? ST_SHORT : ST_HI;
      end
      ST_SHORT, ST_LO: begin
        if (out_ready) begin
          if (accept)
            state_nxt = in_short ? ST_SHORT : ST_HI;
          else
            state_nxt = ST_EMPTY;
        end
      end
      ST_HI: begin
        if (out_ready)
          state_nxt = ST_LO;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Beat presentation; everything is driven to zero while idle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 16'h0000;
    out_ext   = 1'b0;
    out_last  = 1'b0;
    case (state)
      ST_SHORT: begin
        out_valid = 1'b1;
        out_data  = hold[16:31];
        out_ext   = 1'b1;
        out_last  = 1'b1;
      end
      ST_HI: begin
        out_valid = 1'b1;
        out_data  = hold[0:15];
      end
      ST_LO: begin
        out_valid = 1'b1;
        out_data  = hold[16:31];
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // State register; reset discards any word in flight, even between beats.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_EMPTY;
    else
      state <= state_nxt;
  end

  // Holding register captures the word only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (rst)
      hold <= 32'h00000000;
    else if (accept)
      hold <= in_data;
  end

`ifdef SIGN_NARROW_STATS_EN
  // Saturating per-class word counters, bumped on the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_short <= 16'h0000;
      cnt_long  <= 16'h0000;
    end else if (accept) begin
      if (in_short) begin
        if (cnt_short != 16'hffff)
          cnt_short <= cnt_short + 16'h0001;
      end else begin
        if (cnt_long != 16'hffff)
          cnt_long <= cnt_long + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sign_narrow_tx.sv
// Self-checking bench for sign_narrow_tx: a queue-of-beats model checked
// every cycle, plus literal expectations on the logged beat stream.
module tb_sign_narrow_tx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] out_data;
  logic        out_ext;
  logic        out_last;
`ifdef SIGN_NARROW_STATS_EN
  logic [0:15] cnt_short;
  logic [0:15] cnt_long;
`endif

  typedef struct {
    logic [15:0] data;
    logic        ext;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t beat_log[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  bit    armed    = 0;
  int    m_short  = 0;
  int    m_long   = 0;

  sign_narrow_tx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ext   (out_ext),
    .out_last  (out_last)
`ifdef SIGN_NARROW_STATS_EN
    ,
    .cnt_short (cnt_short),
    .cnt_long  (cnt_long)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to time-stamp logged beats.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the pending beats of accepted words, straight from the sign-extension rule.
  always @(negedge clk) begin
    logic  exp_rdy;
    logic  [31:0] w;
    beat_t b;
    if (!armed) begin
      if (rst === 1'b1) begin
        armed = 1;
        exp_q.delete();
        m_short = 0;
        m_long  = 0;
      end
    end else begin
      exp_rdy = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
`ifdef SIGN_NARROW_STATS_EN
      checkOutput("cnt_short", {16'b0, cnt_short}, m_short);
      checkOutput("cnt_long", {16'b0, cnt_long}, m_long);
`endif
      if (out_valid && exp_q.size() != 0) begin
        checkOutput("out_data", {16'b0, out_data}, {16'b0, exp_q[0].data});
        checkOutput("out_ext", {31'b0, out_ext}, {31'b0, exp_q[0].ext});
        checkOutput("out_last", {31'b0, out_last}, {31'b0, exp_q[0].last});
      end
      if (rst) begin
        exp_q.delete();
        m_short = 0;
        m_long  = 0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          b.data = out_data;
          b.ext  = out_ext;
          b.last = out_last;
          b.cyc  = cyc;
          beat_log.push_back(b);
        end
        if (in_valid && exp_rdy) begin
          w = in_data;
          if ($signed({{16{w[15]}}, w[15:0]}) == $signed(w)) begin
            exp_q.push_back('{data: w[15:0], ext: 1'b1, last: 1'b1, cyc: 0});
            if (m_short < 65535) m_short++;
          end else begin
            exp_q.push_back('{data: w[31:16], ext: 1'b0, last: 1'b0, cyc: 0});
            exp_q.push_back('{data: w[15:0], ext: 1'b0, last: 1'b1, cyc: 0});
            if (m_long < 65535) m_long++;
          end
        end
      end
    end
  end

  // Offer one word and hold it until the block takes it.
  task automatic applyStimulus(input logic [31:0] w);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 for %h", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clk);
    while ((out_valid || exp_q.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (out_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got out_valid=1 expected 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat_log.delete();
  endtask

  task automatic check_beat(input string name, input int idx, input logic [15:0] d,
                            input logic e, input logic l);
    if (idx >= beat_log.size()) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got %0d beats expected beat %0d", name, beat_log.size(), idx);
    end else begin
      checkOutput({name, "_data"}, {16'b0, beat_log[idx].data}, {16'b0, d});
      checkOutput({name, "_ext"}, {31'b0, beat_log[idx].ext}, {31'b0, e});
      checkOutput({name, "_last"}, {31'b0, beat_log[idx].last}, {31'b0, l});
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset state
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data", {16'b0, out_data}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    beat_log.delete();

    $display("[TB] short positive");
    applyStimulus(32'h00007fff);
    drain();
    checkOutput("t1_beats", beat_log.size(), 32'd1);
    check_beat("t1_b0", 0, 16'h7fff, 1'b1, 1'b1);
`ifdef SIGN_NARROW_STATS_EN
    checkOutput("t1_cnt_short", {16'b0, cnt_short}, 32'd1);
`endif

    $display("[TB] short negative and long boundary");
    pulse_reset();
    applyStimulus(32'hffff8000);
    applyStimulus(32'h00008000);
    applyStimulus(32'hffff7fff);
    drain();
    checkOutput("t2_beats", beat_log.size(), 32'd5);
    check_beat("t2_b0", 0, 16'h8000, 1'b1, 1'b1);
    check_beat("t2_b1", 1, 16'h0000, 1'b0, 1'b0);
    check_beat("t2_b2", 2, 16'h8000, 1'b0, 1'b1);
    check_beat("t2_b3", 3, 16'hffff, 1'b0, 1'b0);
    check_beat("t2_b4", 4, 16'h7fff, 1'b0, 1'b1);
`ifdef SIGN_NARROW_STATS_EN
    checkOutput("t2_cnt_long", {16'b0, cnt_long}, 32'd2);
    checkOutput("t2_cnt_short", {16'b0, cnt_short}, 32'd1);
`endif

    $display("[TB] backpressure in HI");
    beat_log.delete();
    out_ready = 1'b0;
    applyStimulus(32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hi_data", {16'b0, out_data}, 32'h1234);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    checkOutput("bp_beats", beat_log.size(), 32'd2);
    check_beat("bp_b1", 1, 16'h5678, 1'b0, 1'b1);

    $display("[TB] throughput");
    beat_log.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h00000010 + i;
      @(negedge clk);
      checkOutput("tp_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    checkOutput("tp_beats", beat_log.size(), 32'd8);
    if (beat_log.size() == 8)
      checkOutput("tp_span", beat_log[7].cyc - beat_log[0].cyc, 32'd7);
    check_beat("tp_b7", 7, 16'h0017, 1'b1, 1'b1);

    $display("[TB] reset mid-word");
    out_ready = 1'b0;
    applyStimulus(32'hdeadbeef);
    @(negedge clk);
    checkOutput("rm_hi_data", {16'b0, out_data}, 32'hdead);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    checkOutput("rm_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef SIGN_NARROW_STATS_EN
    checkOutput("rm_cnt_short", {16'b0, cnt_short}, 32'd0);
    checkOutput("rm_cnt_long", {16'b0, cnt_long}, 32'd0);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h00000001);
    drain();
    checkOutput("rm_beats", beat_log.size(), 32'd1);
    check_beat("rm_b0", 0, 16'h0001, 1'b1, 1'b1);

`ifdef SIGN_NARROW_STATS_EN
    $display("[TB] counter saturation");
    pulse_reset();
    in_valid = 1'b1;
    in_data  = 32'hffffffff;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    checkOutput("sat_cnt_short", {16'b0, cnt_short}, 32'h0000ffff);
    checkOutput("sat_cnt_long", {16'b0, cnt_long}, 32'd0);
    beat_log.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
